// File: rtl/snake_ctrl_if.sv
// Signal bundle between snake_ctrl and the input/timebase/food logic and the bitmap path.
interface snake_ctrl_if #(
  parameter int MAX_LEN = 64
);
  logic                    start;
  logic                    tick;
  logic                    dir_valid;
  logic [1:0]              dir_req;
  logic [3:0]              food_col;
  logic [3:0]              food_row;
  logic [MAX_LEN-1:0][3:0] col;
  logic [MAX_LEN-1:0][3:0] row;
  logic [6:0]              length;
  logic                    busy;
  logic                    ate;
  logic                    game_over;
  logic                    win;

  modport master (
    output start, tick, dir_valid, dir_req, food_col, food_row,
    input  col, row, length, busy, ate, game_over, win
  );

  modport slave (
    input  start, tick, dir_valid, dir_req, food_col, food_row,
    output col, row, length, busy, ate, game_over, win
  );
endinterface

// File: rtl/snake_ctrl.sv
// Snake body sequencer: applies a move per tick, scans serially for self-collision,
// grows on food and reports game over / win.
module snake_ctrl #(
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  snake_ctrl_if.slave bus
);
  localparam int         IW     = $clog2(MAX_LEN);
  localparam logic [6:0] MAX_L  = 7'(MAX_LEN);
  localparam logic [6:0] INIT_L = 7'(INIT_LEN);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SCAN, S_MOVE, S_OVER} state_t;
  typedef enum logic [1:0] {D_RIGHT, D_LEFT, D_UP, D_DOWN} dir_t;
  typedef logic [MAX_LEN-1:0][3:0] coord_arr_t;

  function automatic coord_arr_t init_col();
    coord_arr_t v = '0;
    for (int i = 0; i < INIT_LEN; i++) v[i] = 4'(4 - i);
    return v;
  endfunction

  function automatic coord_arr_t init_row();
    coord_arr_t v = '0;
    for (int i = 0; i < INIT_LEN; i++) v[i] = 4'd4;
    return v;
  endfunction

  localparam coord_arr_t INIT_COL = init_col();
  localparam coord_arr_t INIT_ROW = init_row();

  state_t     r_state, w_next;
  coord_arr_t r_col, r_row;
  logic [6:0] r_len;
  dir_t       r_dir, r_pend;
  logic [3:0] r_nh_col, r_nh_row;
  logic       r_eat, r_ate, r_win;
  logic [IW-1:0] r_k, r_last;

  logic [3:0]    w_nh_col, w_nh_row;
  logic [IW-1:0] w_last;
  logic          w_wall, w_eat, w_hit, w_grow, w_restart, w_active, w_dir_ok;

  always_comb begin
    w_nh_col = r_col[0];
    w_nh_row = r_row[0];
    case (r_pend)
      D_RIGHT: w_nh_col = r_col[0] + 4'd1;
      D_LEFT:  w_nh_col = r_col[0] - 4'd1;
      D_UP:    w_nh_row = r_row[0] - 4'd1;
      default: w_nh_row = r_row[0] + 4'd1;
    endcase
  end

  assign w_wall = (w_nh_col == 4'd0) || (w_nh_col == 4'd9) ||
                  (w_nh_row == 4'd0) || (w_nh_row == 4'd9);
  assign w_eat  = (bus.food_col != 4'd0) && (w_nh_col == bus.food_col) &&
                  (w_nh_row == bus.food_row);
  // Without food the tail leaves its cell in the same move, so it is not scanned.
  assign w_last    = w_eat ? r_len[IW-1:0] - IW'(1) : r_len[IW-1:0] - IW'(2);
  assign w_hit     = (r_col[r_k] == r_nh_col) && (r_row[r_k] == r_nh_row);
  assign w_grow    = r_eat && (r_len < MAX_L);
  assign w_restart = bus.start && ((r_state == S_IDLE) || (r_state == S_OVER));
  assign w_active  = (r_state == S_WAIT) || (r_state == S_SCAN) || (r_state == S_MOVE);
  assign w_dir_ok  = bus.dir_valid && w_active && (bus.dir_req != (r_dir ^ 2'd1));

  // NOTE: w_next gets its default before the case, so every path assigns it and no latch forms.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.start) w_next = S_WAIT;
      S_WAIT: if (bus.tick) w_next = w_wall ? S_OVER : S_SCAN;
      S_SCAN: begin
        if (w_hit)              w_next = S_OVER;
        else if (r_k == r_last) w_next = S_MOVE;
      end
      S_MOVE: w_next = (w_grow && (r_len + 7'd1 == MAX_L)) ? S_OVER : S_WAIT;
      S_OVER: if (bus.start) w_next = S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: non-blocking updates so every register here reads pre-edge values of the others.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the segment arrays are visible to the display, so they reset like any other register.
      r_state  <= S_IDLE;
      r_col    <= INIT_COL;
      r_row    <= INIT_ROW;
      r_len    <= INIT_L;
      r_dir    <= D_RIGHT;
      r_pend   <= D_RIGHT;
      r_nh_col <= 4'd0;
      r_nh_row <= 4'd0;
      r_eat    <= 1'b0;
      r_k      <= '0;
      r_last   <= '0;
      r_ate    <= 1'b0;
      r_win    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ate   <= 1'b0;
      if (w_restart) begin
        r_col  <= INIT_COL;
        r_row  <= INIT_ROW;
        r_len  <= INIT_L;
        r_dir  <= D_RIGHT;
        r_pend <= D_RIGHT;
        r_win  <= 1'b0;
      end else begin
        if (w_dir_ok) r_pend <= dir_t'(bus.dir_req);
        case (r_state)
          S_WAIT: if (bus.tick) begin
            r_dir    <= r_pend;
            r_nh_col <= w_nh_col;
            r_nh_row <= w_nh_row;
            r_eat    <= w_eat;
            r_k      <= '0;
            r_last   <= w_last;
          end
          S_SCAN: r_k <= r_k + IW'(1);
          S_MOVE: begin
            r_col <= {r_col[MAX_LEN-2:0], r_nh_col};
            r_row <= {r_row[MAX_LEN-2:0], r_nh_row};
            if (w_grow) begin
              r_len <= r_len + 7'd1;
              r_ate <= 1'b1;
              if (r_len + 7'd1 == MAX_L) r_win <= 1'b1;
            end else if (!r_eat) begin
              r_col[r_len[IW-1:0]] <= 4'd0;
              r_row[r_len[IW-1:0]] <= 4'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.col       = r_col;
  assign bus.row       = r_row;
  assign bus.length    = r_len;
  assign bus.busy      = (r_state == S_SCAN) || (r_state == S_MOVE);
  assign bus.ate       = r_ate;
  assign bus.game_over = (r_state == S_OVER);
  assign bus.win       = r_win;
endmodule

// File: tb/tb_snake_ctrl.sv
// Self-checking bench for snake_ctrl: directed table, hand-written corner sequences,
// and random play against a queue-based model of the snake.
module tb_snake_ctrl;
  localparam int MAX_LEN  = 8;
  localparam int INIT_LEN = 3;
  localparam int W        = MAX_LEN * 4;

  typedef struct packed { logic [3:0] c; logic [3:0] r; } seg_t;

  typedef struct {
    bit         dv;
    logic [1:0] dreq;
    logic [3:0] fc;
    logic [3:0] fr;
    logic [3:0] hc;
    logic [3:0] hr;
    logic [6:0] len;
    int         cyc;
    bit         over;
    int         ate;
  } vec_t;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b0;

  snake_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

  snake_ctrl #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: body as a queue of cells, head first.
  seg_t m_body[$];
  int   m_dir, m_pend;
  bit   m_active, m_go, m_win;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_init();
    m_body = {};
    for (int i = 0; i < INIT_LEN; i++) m_body.push_back(seg_t'{c: 4'(4 - i), r: 4'd4});
    m_dir  = 0;
    m_pend = 0;
    m_go   = 1'b0;
    m_win  = 1'b0;
  endtask

  task automatic m_step(input logic [3:0] fc, input logic [3:0] fr,
                        output int e_cyc, output int e_ate);
    int   c, r, n;
    bit   eat;
    seg_t nh;
    e_cyc = 0;
    e_ate = 0;
    if (!m_active) return;
    m_dir = m_pend;
    c = int'(m_body[0].c);
    r = int'(m_body[0].r);
    case (m_dir)
      0:       c = c + 1;
      1:       c = c - 1;
      2:       r = r - 1;
      default: r = r + 1;
    endcase
    if (c < 1 || c > 8 || r < 1 || r > 8) begin
      m_go = 1'b1; m_active = 1'b0;
      return;
    end
    nh.c = 4'(c);
    nh.r = 4'(r);
    eat  = (fc != 4'd0) && (fc == nh.c) && (fr == nh.r);
    n    = eat ? m_body.size() : m_body.size() - 1;
    for (int j = 0; j < n; j++) begin
      if (m_body[j] == nh) begin
        e_cyc = j + 1;
        m_go = 1'b1; m_active = 1'b0;
        return;
      end
    end
    e_cyc = n + 1;
    m_body.push_front(nh);
    if (eat) e_ate = 1;
    else void'(m_body.pop_back());
    if (m_body.size() == MAX_LEN) begin
      m_win = 1'b1; m_go = 1'b1; m_active = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] exp_vec(input bit want_col);
    logic [W-1:0] v = '0;
    for (int i = 0; i < m_body.size(); i++) v[i*4 +: 4] = want_col ? m_body[i].c : m_body[i].r;
    return v;
  endfunction

  task automatic check_state(input string tag);
    logic [W-1:0] a_col, a_row;
    a_col = bus.col;
    a_row = bus.row;
    check({tag, "_length"}, bus.length, m_body.size());
    check({tag, "_col"}, a_col, exp_vec(1'b1));
    check({tag, "_row"}, a_row, exp_vec(1'b0));
    check({tag, "_game_over"}, bus.game_over, m_go);
    check({tag, "_win"}, bus.win, m_win);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    m_init();
    m_active = 1'b0;
  endtask

  task automatic do_start();
    @(negedge CLK);
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    m_init();
    m_active = 1'b1;
  endtask

  task automatic do_dir(input logic [1:0] d);
    @(negedge CLK);
    bus.dir_valid = 1'b1;
    bus.dir_req   = d;
    @(negedge CLK);
    bus.dir_valid = 1'b0;
    if (m_active && int'(d) != (m_dir ^ 1)) m_pend = int'(d);
  endtask

  task automatic do_move(input logic [3:0] fc, input logic [3:0] fr, input bit extra,
                         output int cyc, output int ate_cnt);
    int e_cyc, e_ate, late_busy;
    @(negedge CLK);
    bus.food_col = fc;
    bus.food_row = fr;
    bus.tick     = 1'b1;
    m_step(fc, fr, e_cyc, e_ate);
    @(negedge CLK);
    bus.tick = 1'b0;
    cyc      = 0;
    ate_cnt  = 0;
    while (bus.busy && cyc < 50) begin
      cyc++;
      ate_cnt += int'(bus.ate);
      bus.tick = extra && (cyc == 1);
      @(negedge CLK);
    end
    bus.tick = 1'b0;
    ate_cnt += int'(bus.ate);
    check("busy_cycles", cyc, e_cyc);
    check_state("move");
    @(negedge CLK);
    ate_cnt += int'(bus.ate);
    check("ate_pulses", ate_cnt, e_ate);
    if (extra) begin
      late_busy = 0;
      for (int i = 0; i < 4; i++) begin
        late_busy += int'(bus.busy);
        @(negedge CLK);
      end
      check("dropped_tick_busy", late_busy, 0);
      check_state("dropped_tick");
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    int   cyc, ate, nreq, fsel, hc, hr;

    bus.start = 1'b0; bus.tick = 1'b0; bus.dir_valid = 1'b0; bus.dir_req = 2'd0;
    bus.food_col = 4'd0; bus.food_row = 4'd0;

    // {dv, dreq, food col, food row, head col, head row, length, busy cycles, over, ate}
    tbl[0] = '{1'b0, 2'd0, 4'd0, 4'd0, 4'd5, 4'd4, 7'd3, 3, 1'b0, 0};
    tbl[1] = '{1'b1, 2'd1, 4'd0, 4'd0, 4'd6, 4'd4, 7'd3, 3, 1'b0, 0};
    tbl[2] = '{1'b0, 2'd0, 4'd7, 4'd4, 4'd7, 4'd4, 7'd4, 4, 1'b0, 1};
    tbl[3] = '{1'b1, 2'd3, 4'd0, 4'd0, 4'd7, 4'd5, 7'd4, 4, 1'b0, 0};
    tbl[4] = '{1'b1, 2'd1, 4'd0, 4'd0, 4'd6, 4'd5, 7'd4, 4, 1'b0, 0};
    tbl[5] = '{1'b1, 2'd2, 4'd0, 4'd0, 4'd6, 4'd4, 7'd4, 4, 1'b0, 0};
    tbl[6] = '{1'b0, 2'd0, 4'd0, 4'd0, 4'd6, 4'd3, 7'd4, 4, 1'b0, 0};

    do_reset();
    check_state("reset");
    check("reset_busy", bus.busy, 1'b0);
    check("reset_ate", bus.ate, 1'b0);

    // IDLE ignores direction and tick.
    do_dir(2'd2);
    do_move(4'd0, 4'd0, 1'b0, cyc, ate);

    do_start();
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].dv) do_dir(tbl[i].dreq);
      do_move(tbl[i].fc, tbl[i].fr, 1'b0, cyc, ate);
      check($sformatf("tbl%0d_head_col", i), bus.col[0], tbl[i].hc);
      check($sformatf("tbl%0d_head_row", i), bus.row[0], tbl[i].hr);
      check($sformatf("tbl%0d_length", i), bus.length, tbl[i].len);
      check($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cyc);
      check($sformatf("tbl%0d_over", i), bus.game_over, tbl[i].over);
      check($sformatf("tbl%0d_ate", i), ate, tbl[i].ate);
    end

    // Last request before the tick wins.
    do_reset(); do_start();
    do_dir(2'd2); do_dir(2'd3);
    do_move(4'd0, 4'd0, 1'b0, cyc, ate);
    check("lastwins_head_col", bus.col[0], 4'd4);
    check("lastwins_head_row", bus.row[0], 4'd5);

    // Wall on the fifth right move; start restores the reset layout.
    do_reset(); do_start();
    for (int i = 0; i < 5; i++) do_move(4'd0, 4'd0, 1'b0, cyc, ate);
    check("wall_over", bus.game_over, 1'b1);
    check("wall_head_col", bus.col[0], 4'd8);
    check("wall_cycles", cyc, 0);
    do_start();
    check_state("restart");
    check("restart_head_col", bus.col[0], 4'd4);

    // Self-collision into the slot-3 segment.
    do_reset(); do_start();
    do_move(4'd5, 4'd4, 1'b0, cyc, ate);
    do_move(4'd6, 4'd4, 1'b0, cyc, ate);
    check("self_grown_len", bus.length, 7'd5);
    do_dir(2'd3); do_move(4'd0, 4'd0, 1'b0, cyc, ate);
    do_dir(2'd1); do_move(4'd0, 4'd0, 1'b0, cyc, ate);
    do_dir(2'd2); do_move(4'd0, 4'd0, 1'b0, cyc, ate);
    check("self_over", bus.game_over, 1'b1);
    check("self_cycles", cyc, 4);
    check("self_len", bus.length, 7'd5);

    // Win at MAX_LEN.
    do_reset(); do_start();
    do_move(4'd5, 4'd4, 1'b0, cyc, ate);
    do_move(4'd6, 4'd4, 1'b0, cyc, ate);
    do_move(4'd7, 4'd4, 1'b0, cyc, ate);
    do_move(4'd8, 4'd4, 1'b0, cyc, ate);
    do_dir(2'd3);
    do_move(4'd8, 4'd5, 1'b0, cyc, ate);
    check("win_flag", bus.win, 1'b1);
    check("win_over", bus.game_over, 1'b1);
    check("win_len", bus.length, 7'(MAX_LEN));
    check("win_cycles", cyc, MAX_LEN);
    check("win_ate", ate, 1);

    // Reset in the middle of SCAN.
    do_reset(); do_start();
    @(negedge CLK);
    bus.food_col = 4'd0; bus.tick = 1'b1;
    @(negedge CLK);
    bus.tick = 1'b0;
    check("midscan_busy_before", bus.busy, 1'b1);
    RESET_N = 1'b0;
    m_init();
    m_active = 1'b0;
    #1;
    check_state("midscan_reset");
    check("midscan_busy_after", bus.busy, 1'b0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Tick while busy is dropped.
    do_start();
    do_move(4'd0, 4'd0, 1'b1, cyc, ate);
    check("dropped_head_col", bus.col[0], 4'd5);

    // Random play against the model.
    do_reset(); do_start();
    for (int it = 0; it < 300; it++) begin
      if (!m_active) begin
        do_start();
        check_state("rand_restart");
      end
      nreq = $urandom_range(0, 2);
      for (int q = 0; q < nreq; q++) do_dir(2'($urandom_range(0, 3)));
      fsel = $urandom_range(0, 2);
      hc = int'(m_body[0].c);
      hr = int'(m_body[0].r);
      case (m_pend)
        0:       hc = hc + 1;
        1:       hc = hc - 1;
        2:       hr = hr - 1;
        default: hr = hr + 1;
      endcase
      if (fsel == 1 && hc >= 1 && hc <= 8 && hr >= 1 && hr <= 8)
        do_move(4'(hc), 4'(hr), 1'b0, cyc, ate);
      else if (fsel == 2)
        do_move(4'($urandom_range(1, 8)), 4'($urandom_range(1, 8)), 1'b0, cyc, ate);
      else
        do_move(4'd0, 4'd0, 1'b0, cyc, ate);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
